// File: rtl/fft_stream_pkg.sv
// Shared sizing, bin type and stream FSM encoding for the FFT frame streamer.
package fft_stream_pkg;
  localparam int TOTAL_SIZE = 512;
  localparam int OUT_LANES  = 16;
  localparam int WIDTH_BIN  = 13;
  localparam int WIDTH_DROP = 8;
  localparam int NUM_BEATS  = TOTAL_SIZE / OUT_LANES;
  localparam int BEAT_W     = $clog2(NUM_BEATS);

  typedef logic signed [WIDTH_BIN-1:0] bin_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;
endpackage

// File: rtl/fft_frame_slot.sv
// One frame register bank: whole-frame capture, beat-indexed read of OUT_LANES bins.
module fft_frame_slot
  import fft_stream_pkg::*;
#(
  parameter int TOTAL_SIZE = fft_stream_pkg::TOTAL_SIZE,
  parameter int OUT_LANES  = fft_stream_pkg::OUT_LANES,
  parameter int WIDTH_BIN  = fft_stream_pkg::WIDTH_BIN
) (
  input  logic                                     clk,
  input  logic                                     cap_i,
  input  logic [TOTAL_SIZE-1:0][WIDTH_BIN-1:0]     re_i,
  input  logic [TOTAL_SIZE-1:0][WIDTH_BIN-1:0]     im_i,
  input  logic [$clog2(TOTAL_SIZE/OUT_LANES)-1:0]  beat_i,
  output logic [OUT_LANES-1:0][WIDTH_BIN-1:0]      re_o,
  output logic [OUT_LANES-1:0][WIDTH_BIN-1:0]      im_o
);
  localparam int NB = TOTAL_SIZE / OUT_LANES;

  // Bin n lands at [n/OUT_LANES][n%OUT_LANES], so a beat is one row.
  logic [NB-1:0][OUT_LANES-1:0][WIDTH_BIN-1:0] re_q, im_q;

  always_ff @(posedge clk) begin
    if (cap_i) begin
      re_q <= re_i;
      im_q <= im_i;
    end
  end

  assign re_o = re_q[beat_i];
  assign im_o = im_q[beat_i];
endmodule

// File: rtl/fft_frame_streamer.sv
// Ping-pong frame capture from the FFT core, streamed out as OUT_LANES-wide beats.
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int TOTAL_SIZE = fft_stream_pkg::TOTAL_SIZE,
  parameter int OUT_LANES  = fft_stream_pkg::OUT_LANES,
  parameter int WIDTH_BIN  = fft_stream_pkg::WIDTH_BIN,
  parameter int WIDTH_DROP = fft_stream_pkg::WIDTH_DROP
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     fft_en,
  input  logic [TOTAL_SIZE-1:0][WIDTH_BIN-1:0]     fft_re,
  input  logic [TOTAL_SIZE-1:0][WIDTH_BIN-1:0]     fft_im,
  output logic                                     frame_ready,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [OUT_LANES-1:0][WIDTH_BIN-1:0]      m_re,
  output logic [OUT_LANES-1:0][WIDTH_BIN-1:0]      m_im,
  output logic [$clog2(TOTAL_SIZE/OUT_LANES)-1:0]  m_beat,
  output logic                                     m_last,
  output logic [WIDTH_DROP-1:0]                    drop_cnt
);
  localparam int NB = TOTAL_SIZE / OUT_LANES;
  localparam int BW = $clog2(NB);

  stream_state_t           st_q, st_d;
  logic [1:0]              full_q, full_d;
  logic                    wr_q, wr_d, rd_q, rd_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [WIDTH_DROP-1:0]   drop_q, drop_d;

  logic                    both_full, cap, last_beat;
  logic [1:0][OUT_LANES-1:0][WIDTH_BIN-1:0] slot_re, slot_im;

  assign both_full = &full_q;
  assign cap       = fft_en & ~both_full;
  assign last_beat = (beat_q == BW'(NB - 1));

  for (genvar s = 0; s < 2; s++) begin : g_slot
    fft_frame_slot #(
      .TOTAL_SIZE (TOTAL_SIZE),
      .OUT_LANES  (OUT_LANES),
      .WIDTH_BIN  (WIDTH_BIN)
    ) u_slot (
      .clk    (clk),
      .cap_i  (cap && (wr_q == 1'(s))),
      .re_i   (fft_re),
      .im_i   (fft_im),
      .beat_i (beat_q),
      .re_o   (slot_re[s]),
      .im_o   (slot_im[s])
    );
  end

  always_comb begin
    st_d   = st_q;
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    beat_d = beat_q;
    drop_d = drop_q;

    // Slot availability is judged from pre-edge flags: a slot freed this cycle
    // cannot take a frame arriving in the same cycle.
    if (fft_en) begin
      if (both_full) begin
        if (drop_q != {WIDTH_DROP{1'b1}}) drop_d = drop_q + WIDTH_DROP'(1);
      end else begin
        full_d[wr_q] = 1'b1;
        wr_d         = ~wr_q;
      end
    end

    case (st_q)
      IDLE: begin
        if (full_q[rd_q]) st_d = STREAM;
      end
      STREAM: begin
        if (m_ready) begin
          if (last_beat) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
            beat_d       = '0;
            st_d         = full_q[~rd_q] ? STREAM : IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      full_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      beat_q <= '0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      beat_q <= beat_d;
      drop_q <= drop_d;
    end
  end

  assign m_valid     = (st_q == STREAM);
  assign m_re        = m_valid ? slot_re[rd_q] : '0;
  assign m_im        = m_valid ? slot_im[rd_q] : '0;
  assign m_beat      = beat_q;
  assign m_last      = m_valid & last_beat;
  assign frame_ready = ~both_full;
  assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scenario bench for fft_frame_streamer against a frame-queue reference model.
module tb_fft_frame_streamer;
  localparam int N  = 512;
  localparam int L  = 16;
  localparam int W  = 13;
  localparam int NB = N / L;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef logic [L-1:0][W-1:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_en = 1'b0;
  frame_t      fft_re = '0, fft_im = '0;
  logic        frame_ready, m_valid, m_last;
  logic        m_ready = 1'b0;
  beat_t       m_re, m_im;
  logic [4:0]  m_beat;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  fft_frame_streamer dut (
    .clk(clk), .rst(rst), .fft_en(fft_en), .fft_re(fft_re), .fft_im(fft_im),
    .frame_ready(frame_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_re(m_re), .m_im(m_im), .m_beat(m_beat), .m_last(m_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic beat_t beat_of(frame_t f, int k);
    beat_t b;
    for (int j = 0; j < L; j++) b[j] = f[L*k + j];
    return b;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int n = 0; n < N; n++) f[n] = W'($urandom);
    return f;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fft_en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one frame for a single edge; returns at the negedge after capture.
  task automatic pulse(input frame_t re, input frame_t im);
    fft_en = 1'b1; fft_re = re; fft_im = im;
    @(negedge clk);
    fft_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; fft_en = 1'b0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
    checks++; if (m_beat !== 5'd0) begin errors++; $display("FAIL reset_beat got %0d want 0", m_beat); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", m_last); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_frame_ready got %b want 1", frame_ready); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (m_re !== '0 || m_im !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0", m_re, m_im); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    frame_t re, im;
    for (int n = 0; n < N; n++) begin re[n] = W'(n - 256); im[n] = W'(-n); end
    m_ready = 1'b1;
    pulse(re, im);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_latency0 got valid %b want 0", m_valid); end
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (m_valid !== 1'b1 || m_beat !== 5'(k) || m_last !== (k == NB - 1)) begin
        errors++; $display("FAIL single_ctrl k=%0d got v%b b%0d l%b", k, m_valid, m_beat, m_last);
      end
      checks++;
      if (m_re !== beat_of(re, k) || m_im !== beat_of(im, k)) begin
        errors++; $display("FAIL single_data k=%0d got %h want %h", k, m_re, beat_of(re, k));
      end
      if (k == 5) begin
        checks++;
        if (m_re[3] !== W'(-173) || m_im[3] !== W'(-83)) begin
          errors++; $display("FAIL single_b5l3 got re %0d im %0d want -173 -83",
                             $signed(m_re[3]), $signed(m_im[3]));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0 || frame_ready !== 1'b1) begin
      errors++; $display("FAIL single_idle got v%b fr%b want v0 fr1", m_valid, frame_ready);
    end
  endtask

  task automatic test_stall();
    frame_t re = rand_frame(), im = rand_frame();
    logic [3:0] pat = 4'b1001;
    int exp_k = 0;
    logic stalled = 1'b0;
    beat_t pre, pim;
    logic [4:0] pbeat;
    m_ready = 1'b0;
    pulse(re, im);
    for (int cyc = 0; cyc < 200 && exp_k < NB; cyc++) begin
      if (m_valid) begin
        checks++;
        if (m_beat !== 5'(exp_k) || m_last !== (exp_k == NB - 1) ||
            m_re !== beat_of(re, exp_k) || m_im !== beat_of(im, exp_k)) begin
          errors++; $display("FAIL stall_beat got b%0d want b%0d", m_beat, exp_k);
        end
        if (stalled) begin
          checks++;
          if (m_re !== pre || m_im !== pim || m_beat !== pbeat) begin
            errors++; $display("FAIL stall_hold got b%0d want b%0d", m_beat, pbeat);
          end
        end
      end
      m_ready = pat[cyc % 4];
      stalled = m_valid && !m_ready;
      pre = m_re; pim = m_im; pbeat = m_beat;
      if (m_valid && m_ready) exp_k++;
      @(negedge clk);
    end
    checks++; if (exp_k != NB) begin errors++; $display("FAIL stall_count got %0d want %0d", exp_k, NB); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    frame_t ar = rand_frame(), ai = rand_frame(), br = rand_frame(), bi = rand_frame();
    m_ready = 1'b1;
    for (int cyc = 0; cyc <= 2 * NB + 2; cyc++) begin
      if (cyc >= 2 && cyc < 2 * NB + 2) begin
        int n = cyc - 2;
        checks++;
        if (m_valid !== 1'b1 || m_beat !== 5'(n % NB)) begin
          errors++; $display("FAIL b2b_ctrl n=%0d got v%b b%0d", n, m_valid, m_beat);
        end
        checks++;
        if (m_re !== beat_of(n < NB ? ar : br, n % NB) || m_im !== beat_of(n < NB ? ai : bi, n % NB)) begin
          errors++; $display("FAIL b2b_data n=%0d got %h", n, m_re);
        end
      end else if (cyc == 2 * NB + 2) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", m_valid); end
      end
      fft_en = (cyc == 0 || cyc == 3);
      fft_re = (cyc == 0) ? ar : br;
      fft_im = (cyc == 0) ? ai : bi;
      @(negedge clk);
    end
    fft_en = 1'b0;
  endtask

  task automatic test_drop();
    frame_t r1 = rand_frame(), i1 = rand_frame(), r2 = rand_frame(), i2 = rand_frame();
    int n = 0;
    do_reset();
    m_ready = 1'b0;
    pulse(r1, i1);
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL drop_fr1 got %b want 1", frame_ready); end
    @(negedge clk);
    pulse(r2, i2);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL drop_fr2 got %b want 0", frame_ready); end
    pulse(rand_frame(), rand_frame());
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (m_valid) begin
        checks++;
        if (n >= 2 * NB) begin
          errors++; $display("FAIL drop_extra_beat got b%0d want none", m_beat);
        end else if (m_beat !== 5'(n % NB) || m_re !== beat_of(n < NB ? r1 : r2, n % NB) ||
                     m_im !== beat_of(n < NB ? i1 : i2, n % NB)) begin
          errors++; $display("FAIL drop_stream n=%0d got b%0d", n, m_beat);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 2 * NB) begin errors++; $display("FAIL drop_beats got %0d want %0d", n, 2 * NB); end
  endtask

  task automatic test_saturate();
    do_reset();
    m_ready = 1'b0;
    fft_en = 1'b1; fft_re = rand_frame(); fft_im = rand_frame();
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 102) begin
        checks++; if (drop_cnt !== 8'd100) begin errors++; $display("FAIL sat_mid got %0d want 100", drop_cnt); end
      end
    end
    fft_en = 1'b0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_end got %0d want 255", drop_cnt); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL sat_fr got %b want 0", frame_ready); end
  endtask

  task automatic test_reset_mid();
    frame_t r4 = rand_frame(), i4 = rand_frame();
    logic found = 1'b0;
    logic quiet = 1'b1;
    int n = 0;
    do_reset();
    m_ready = 1'b0;
    pulse(rand_frame(), rand_frame());
    pulse(rand_frame(), rand_frame());
    pulse(rand_frame(), rand_frame());
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_valid && m_beat == 5'd10) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach got none want beat 10"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || frame_ready !== 1'b1 || drop_cnt !== 8'd0 || m_beat !== 5'd0) begin
      errors++; $display("FAIL rmid_state got v%b fr%b d%0d b%0d want v0 fr1 d0 b0",
                         m_valid, frame_ready, drop_cnt, m_beat);
    end
    for (int i = 0; i < 5; i++) begin
      if (m_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rmid_quiet got valid 1 want 0"); end
    pulse(r4, i4);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (m_valid) begin
        checks++;
        if (n >= NB || m_beat !== 5'(n) || m_re !== beat_of(r4, n) || m_im !== beat_of(i4, n)) begin
          errors++; $display("FAIL rmid_stream n=%0d got b%0d", n, m_beat);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != NB) begin errors++; $display("FAIL rmid_beats got %0d want %0d", n, NB); end
  endtask

  task automatic test_random();
    frame_t qr[$], qi[$];
    int exp_k = 0;
    int drop_m = 0;
    int frames_out = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      checks++;
      if (frame_ready !== (qr.size() < 2) || drop_cnt !== 8'(drop_m)) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got fr%b d%0d want fr%b d%0d",
                           cyc, frame_ready, drop_cnt, qr.size() < 2, drop_m);
      end
      if (m_valid) begin
        checks++;
        if (qr.size() == 0) begin
          errors++; $display("FAIL rnd_spurious cyc=%0d got valid want idle", cyc);
        end else if (m_beat !== 5'(exp_k) || m_last !== (exp_k == NB - 1) ||
                     m_re !== beat_of(qr[0], exp_k) || m_im !== beat_of(qi[0], exp_k)) begin
          errors++; $display("FAIL rnd_beat cyc=%0d got b%0d want b%0d", cyc, m_beat, exp_k);
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      fft_en  = ($urandom_range(0, 19) == 0);
      if (fft_en) begin
        fft_re = rand_frame(); fft_im = rand_frame();
        if (qr.size() < 2) begin qr.push_back(fft_re); qi.push_back(fft_im); end
        else if (drop_m < 255) drop_m++;
      end
      if (m_valid && m_ready && qr.size() > 0) begin
        if (exp_k == NB - 1) begin
          void'(qr.pop_front()); void'(qi.pop_front());
          exp_k = 0; frames_out++;
        end else exp_k++;
      end
      @(negedge clk);
    end
    fft_en = 1'b0;
    checks++; if (frames_out < 4) begin errors++; $display("FAIL rnd_progress got %0d frames want >=4", frames_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_drop();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Receive-side companion of the FFT core's frame output.
- Captures a full 512-bin frame (re/im, 13-bit signed) when the core's output enable pulses.
- Streams each frame back out as 32 beats of 16 bins per beat over a valid/ready handshake, mirroring the 16-lane input format the core accepts.
- Two frame slots (ping-pong) allow capture during streaming; a frame that arrives with no free slot is dropped and counted.

Parameters:
- TOTAL_SIZE, 512, bins per frame
- OUT_LANES, 16, bins per output beat (TOTAL_SIZE divisible by OUT_LANES)
- WIDTH_BIN, 13, signed bin width
- WIDTH_DROP, 8, drop counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- fft_en  in  1  one-cycle pulse: fft_re/fft_im hold a valid frame this cycle
- fft_re  in  WIDTH_BIN x TOTAL_SIZE  signed real bins, natural order
- fft_im  in  WIDTH_BIN x TOTAL_SIZE  signed imaginary bins
- frame_ready  out  1  at least one slot free
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_re  out  WIDTH_BIN x OUT_LANES  signed real lanes
- m_im  out  WIDTH_BIN x OUT_LANES  signed imaginary lanes
- m_beat  out  log2(TOTAL_SIZE/OUT_LANES)=5  beat index within frame
- m_last  out  1  final beat of frame (m_beat==31)
- drop_cnt  out  WIDTH_DROP  saturating count of dropped frames

Behaviour:
- Interface is decided: one clock; reset is synchronous and active-high.
- Reset (rst high at a clock edge) sets both slots empty, wr_slot=0, rd_slot=0, beat=0, state IDLE, drop_cnt=0.
  - m_valid=0, m_beat=0, m_last=0, frame_ready=1.
  - Reset mid-stream abandons both slots with no partial completion.
- m_re/m_im are forced to 0 whenever m_valid=0.
- Capture: fft_en=1 and a slot free (evaluated from state at start of cycle):
  - All TOTAL_SIZE bins are copied into slot wr_slot at that edge.
  - The slot is marked full and wr_slot toggles.
- Drop: fft_en=1 with both slots full. The frame is discarded and drop_cnt increments, saturating at 2^WIDTH_DROP-1. This holds even if the last beat of the reading slot completes in the same cycle; no bypass.
- frame_ready = NOT(both slots full), derived from registered state only.
- States:
  - IDLE: m_valid=0. Goes to STREAM on the edge after slot rd_slot becomes full.
  - STREAM: m_valid=1. Lane j of beat k = bin OUT_LANES*k+j of slot rd_slot.
- Latency: fft_en at edge t with both slots empty gives m_valid=1, m_beat=0 after edge t+1.
- Handshake:
  - Beat transfers when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_re/m_im/m_beat/m_last hold stable.
  - m_valid never drops without a transfer.
- On transfer with beat<31: beat increments.
- On transfer with beat=31:
  - Slot rd_slot is marked empty, rd_slot toggles, beat=0.
  - If the other slot is full, the FSM stays in STREAM and beat 0 of the next frame is valid the next cycle with no bubble. Otherwise it returns to IDLE.
- Simultaneous capture into the slot being freed is impossible: the free slot is computed pre-edge.
- Capture into the non-reading slot while streaming never disturbs beats in flight.
- Arithmetic: no scaling or rounding; bins are passed bit-exact, sign preserved.

Decomposition:
- Package fft_stream_pkg holds:
  - localparams NUM_BEATS=TOTAL_SIZE/OUT_LANES and BEAT_W=$clog2(NUM_BEATS)
  - typedef bin_t = logic signed [WIDTH_BIN-1:0]
  - enum stream_state_t {IDLE, STREAM}
- One natural sub-module, fft_frame_slot: a single frame register bank with a capture enable and a beat-indexed 16-lane read mux, instantiated twice.
- The FSM, slot flags, and drop counter stay in the top.

Test Plan:
- Reset, then one frame with re[n]=n-256 and im[n]=-n, m_ready=1 -> m_valid after 1 cycle; 32 consecutive beats; beat 5 lane 3 carries re=-173, im=-83; m_last only on beat 31; then IDLE.
- Same frame with m_ready toggling 1,0,0,1 -> outputs held stable during stalls; 32 beats total with no duplicate or skip of m_beat.
- Two frames 3 cycles apart with m_ready=1 -> frame B beat 0 immediately follows frame A beat 31 (no idle cycle); frame B data exact.
- m_ready=0, three fft_en pulses -> frame_ready falls after the 2nd; 3rd is dropped, drop_cnt=1; releasing m_ready streams frames 1 and 2 only.
- 300 fft_en pulses with m_ready=0 -> drop_cnt saturates at 255.
- rst asserted during beat 10 of frame 1 with frame 2 buffered -> next cycle m_valid=0, frame_ready=1, drop_cnt=0; a new frame afterwards streams from beat 0.
